alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational ALU.
- Two-stage datapath with valid/ready handshake on both sides.
- Shifts and rotates take a variable amount from B.
- Registered flags: Z, N, V, C, plus a carry-flag register so multi-word add/sub chains run without software carry handling.
- Sits between the register-file read stage and write-back.

Parameters:
- WIDTH, 16, operand/result width in bits; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op present.
- in_ready  output  1  block accepts input this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift/rotate ops.
- Cin  input  1  explicit carry/borrow-in.
- use_cf  input  1  1: effective carry-in = CF register; 0: effective carry-in = Cin.
- OP  input  4  operation code.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- C  output  WIDTH  result.
- Cout  output  1  carry (add) / borrow (sub); 0 for all other ops.
- flag_z  output  1  C == 0.
- flag_n  output  1  C[WIDTH-1].
- flag_v  output  1  signed overflow (add/sub only, else 0).
- cf  output  1  current carry-flag register.

Behaviour:
- Reset (async, active-high): s1_valid=0, out_valid=0, C=0, Cout=0, flag_z/n/v=0, cf=0; in_ready=1 once reset deasserts.
  - Reset mid-operation discards all in-flight ops; no partial results emerge.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=1, S1 and S2 registers and CF all hold.
- S1 (input stage):
  - On edge with in_ready=1: s1_valid <= in_valid; if in_valid, capture A, B, Cin, use_cf, OP.
- S2 (output stage):
  - On edge with ~stall: out_valid <= s1_valid.
  - If s1_valid: compute from S1 registers and register C, Cout, flags.
- Latency: 2 cycles from accepted input to out_valid with no stall; throughput 1 op/cycle.
- Effective carry ci = use_cf ? cf : Cin. cf is sampled at compute time (S1->S2 transfer).
- CF update: cf <= Cout only when an ADD or SUB op moves S1->S2. Other ops leave cf unchanged.
  - Back-to-back chained ops therefore see the previous op's carry with no bubble.
- OP encoding (unchanged from the 16-bit generation), all results WIDTH bits:
  - 0000 ADD: {Cout,C} = A+B+ci; V = (A[msb]==B[msb]) & (C[msb]!=A[msb]).
  - 0001 SUB: C = A-B-ci (mod 2^WIDTH); Cout = borrow = ({0,A} < {0,B}+ci); V = (A[msb]!=B[msb]) & (C[msb]!=A[msb]).
  - 0010 C=A; 0011 NAND; 0100 NOR; 0101 XNOR; 0110 C=~A; 0111 AND; 1000 OR; 1001 XOR.
  - Shift/rotate ops use s = B[SHW-1:0]; s=0 gives C=A:
    - 1010 logical right by s.
    - 1011 arithmetic right by s (sign fill).
    - 1100 rotate right by s.
    - 1101 logical left by s.
    - 1110 arithmetic left by s (identical to 1101).
    - 1111 rotate left by s.
- Flags: flag_z and flag_n are valid for every op. flag_v and Cout are 0 for ops other than ADD/SUB.
- Outputs C, Cout and flags hold their value while out_valid=1 and out_ready=0.
  - When out_valid=0, C and flags hold the last value (don't-care for the consumer).
- in_valid=0 with in_ready=1 inserts a bubble (s1_valid=0). Bubbles never modify cf.

Test Plan:
- Reset, then ADD A=16'hFFFF, B=16'h0001, Cin=0, use_cf=0 -> out_valid at cycle 2; C=16'h0000, Cout=1, flag_z=1, flag_v=0, cf=1.
- 32-bit chain on WIDTH=16:
  - Op 1: ADD A=16'hFFFF, B=16'h0001, use_cf=0, Cin=0.
  - Op 2, next cycle: ADD A=16'h0000, B=16'h0000, use_cf=1.
  - -> second result C=16'h0001, cf ends 0.
  - Same chain with SUB: A=16'h0000, B=16'h0001 -> C=16'hFFFF, Cout=1; then SUB 0-0 with use_cf=1 -> C=16'hFFFF, Cout=1.
- Overflow and shifts:
  - ADD 16'h7FFF + 16'h0001 -> C=16'h8000, flag_v=1, flag_n=1.
  - OP=1011, A=16'h8000, B=4 -> C=16'hF800.
  - OP=1111, A=16'h8001, B=1 -> C=16'h0003.
  - OP=1010, B=0 -> C=A.
- Backpressure:
  - Stream 4 ADDs with out_ready held 0 from cycle 2 -> in_ready=0 while stalled; first result held stable.
  - Release out_ready -> all 4 results emerge in order, none lost or duplicated, cf equals the 4th op's Cout.
- Reset mid-stream: assert reset asynchronously with 2 ops in flight -> out_valid, cf, C drop to 0 immediately; after release, the first new op's result appears 2 cycles after acceptance.
- Parametrisation: WIDTH=32, OP=1100, A=32'h0000_0001, B=31 -> C=32'h0000_0002; ADD 32'hFFFF_FFFF+1 -> Cout=1, flag_z=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 registers the operands; S2 computes and registers the result, flags and the
// carry-flag register used to chain multi-word add/sub sequences.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             use_cf,
   input  logic [3:0]       OP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             Cout,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             cf
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_PASS = 4'b0010;
   localparam logic [3:0] OP_NAND = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_XNOR = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
   localparam logic [3:0] OP_ASR  = 4'b1011;
   localparam logic [3:0] OP_ROR  = 4'b1100;
   localparam logic [3:0] OP_LSL  = 4'b1101;
   localparam logic [3:0] OP_ASL  = 4'b1110;
   localparam logic [3:0] OP_ROL  = 4'b1111;

   logic             s1_valid_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q, use_cf_q;
   logic [3:0]       op_q;

   logic             out_valid_q;
   logic [WIDTH-1:0] c_q;
   logic             cout_q, z_q, n_q, v_q, cf_q;

   logic             stall;
   logic             ci;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   sum_d;
   logic [2*WIDTH-1:0] rot_d;
   logic [WIDTH-1:0] res_d;
   logic             cout_d, v_d, arith_d;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;

   // Result, carry and overflow computed from the S1 registers.
   always_comb begin
      ci      = use_cf_q ? cf_q : cin_q;
      sh      = b_q[SHW-1:0];
      sum_d   = '0;
      rot_d   = (op_q == OP_ROL) ? ({a_q, a_q} << sh) : ({a_q, a_q} >> sh);
      res_d   = a_q;
      cout_d  = 1'b0;
      v_d     = 1'b0;
      arith_d = 1'b0;
      case (op_q)
         OP_ADD: begin
            sum_d   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci};
            res_d   = sum_d[WIDTH-1:0];
            cout_d  = sum_d[WIDTH];
            v_d     = (a_q[MSB] == b_q[MSB]) & (res_d[MSB] != a_q[MSB]);
            arith_d = 1'b1;
         end
         OP_SUB: begin
            // Top bit of the widened difference is the borrow.
            sum_d   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ci};
            res_d   = sum_d[WIDTH-1:0];
            cout_d  = sum_d[WIDTH];
            v_d     = (a_q[MSB] != b_q[MSB]) & (res_d[MSB] != a_q[MSB]);
            arith_d = 1'b1;
         end
         OP_PASS: res_d = a_q;
         OP_NAND: res_d = ~(a_q & b_q);
         OP_NOR:  res_d = ~(a_q | b_q);
         OP_XNOR: res_d = ~(a_q ^ b_q);
         OP_NOT:  res_d = ~a_q;
         OP_AND:  res_d = a_q & b_q;
         OP_OR:   res_d = a_q | b_q;
         OP_XOR:  res_d = a_q ^ b_q;
         OP_LSR:  res_d = a_q >> sh;
         OP_ASR:  res_d = $signed(a_q) >>> sh;
         OP_ROR:  res_d = rot_d[WIDTH-1:0];
         OP_LSL:  res_d = a_q << sh;
         OP_ASL:  res_d = a_q << sh;
         OP_ROL:  res_d = rot_d[2*WIDTH-1:WIDTH];
         default: res_d = a_q;
      endcase
   end

   // S1: capture operands whenever the pipeline is not stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         use_cf_q   <= 1'b0;
         op_q       <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            cin_q    <= Cin;
            use_cf_q <= use_cf;
            op_q     <= OP;
         end
      end
   end

   // S2: register result and flags; cf only follows add/sub so bubbles and logic ops keep it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         c_q         <= '0;
         cout_q      <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         cf_q        <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            c_q    <= res_d;
            cout_q <= cout_d;
            z_q    <= ~|res_d;
            n_q    <= res_d[MSB];
            v_q    <= v_d;
            if (arith_d) cf_q <= cout_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign C         = c_q;
   assign Cout      = cout_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_v    = v_q;
   assign cf        = cf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 16-bit and a 32-bit instance share clock and reset.
`timescale 1ns/1ps
module tb_alu_pipe;

   localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, PAS = 4'h2, NAN = 4'h3;
   localparam logic [3:0] NOR = 4'h4, XNR = 4'h5, NOT = 4'h6, AND = 4'h7;
   localparam logic [3:0] ORR = 4'h8, XOR = 4'h9, LSR = 4'hA, ASR = 4'hB;
   localparam logic [3:0] ROR = 4'hC, LSL = 4'hD, ASL = 4'hE, ROL = 4'hF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        iv16, ir16, cin16, ucf16, ov16, or16, co16, z16, n16, v16, cf16;
   logic [15:0] a16, b16, c16;
   logic [3:0]  op16;
   logic        iv32, ir32, cin32, ucf32, ov32, or32, co32, z32, n32, v32, cf32;
   logic [31:0] a32, b32, c32;
   logic [3:0]  op32;

   alu_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
      .Cin(cin16), .use_cf(ucf16), .OP(op16), .out_valid(ov16), .out_ready(or16),
      .C(c16), .Cout(co16), .flag_z(z16), .flag_n(n16), .flag_v(v16), .cf(cf16));

   alu_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
      .Cin(cin32), .use_cf(ucf32), .OP(op32), .out_valid(ov32), .out_ready(or32),
      .C(c32), .Cout(co32), .flag_z(z32), .flag_n(n32), .flag_v(v32), .cf(cf32));

   // Expected response: {C, Cout, Z, N, V, cf-after-op}
   typedef struct packed {
      logic [31:0] c;
      logic        cout, z, n, v, cf;
   } exp_t;

   exp_t q16[$];
   exp_t q32[$];
   exp_t e16, e32;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitors: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (!reset && ov16 && or16) begin
         if (q16.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res16_extra: got C=%h with empty scoreboard, expected no result", c16);
         end else begin
            e16 = q16.pop_front();
            check("res16", 64'({16'h0, c16, co16, z16, n16, v16, cf16}), 64'(e16));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && ov32 && or32) begin
         if (q32.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res32_extra: got C=%h with empty scoreboard, expected no result", c32);
         end else begin
            e32 = q32.pop_front();
            check("res32", 64'({c32, co32, z32, n32, v32, cf32}), 64'(e32));
         end
      end
   end

   // ci_uc = {Cin, use_cf}; fl = {Cout, Z, N, V, cf-after}
   task automatic send(input logic w32, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] ci_uc,
                       input logic [31:0] ec, input logic [4:0] fl);
      int t;
      exp_t e;
      e = {ec, fl};
      @(negedge clk);
      if (w32) begin
         iv32 = 1'b1; op32 = op; a32 = a; b32 = b; cin32 = ci_uc[1]; ucf32 = ci_uc[0];
      end else begin
         iv16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; cin16 = ci_uc[1]; ucf16 = ci_uc[0];
      end
      t = 0;
      while ((w32 ? !ir32 : !ir16) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready was 0 for %0d cycles, expected 1", t);
         iv16 = 1'b0;
         iv32 = 1'b0;
         return;
      end
      if (w32) q32.push_back(e);
      else     q16.push_back(e);
      @(posedge clk);
      #1;
      iv16 = 1'b0;
      iv32 = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q16.size() != 0 || q32.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(q16.size() + q32.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      reset = 1'b1;
      iv16 = 0; op16 = 0; a16 = 0; b16 = 0; cin16 = 0; ucf16 = 0; or16 = 1;
      iv32 = 0; op32 = 0; a32 = 0; b32 = 0; cin32 = 0; ucf32 = 0; or32 = 1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_state16", 64'({ov16, ir16, c16, co16, z16, n16, v16, cf16}), 64'({2'b01, 16'h0, 5'b0}));
      check("reset_state32", 64'({ov32, ir32, c32, co32, z32, n32, v32, cf32}), 64'({2'b01, 32'h0, 5'b0}));

      // First ADD and its two-cycle latency
      send(1'b0, ADD, 32'hFFFF, 32'h0001, 2'b00, 32'h0000, 5'b11001);
      check("lat_cycle1", 64'(ov16), 64'd0);
      @(posedge clk); #1;
      check("lat_cycle2", 64'(ov16), 64'd1);

      // Carry / borrow chains
      send(1'b0, ADD, 32'hFFFF, 32'h0001, 2'b00, 32'h0000, 5'b11001);
      send(1'b0, ADD, 32'h0000, 32'h0000, 2'b01, 32'h0001, 5'b00000);
      send(1'b0, SUB, 32'h0000, 32'h0001, 2'b00, 32'hFFFF, 5'b10101);
      send(1'b0, SUB, 32'h0000, 32'h0000, 2'b01, 32'hFFFF, 5'b10101);
      // Shifts, rotates and logic ops leave cf=1 untouched
      send(1'b0, ASR, 32'h8000, 32'h0004, 2'b00, 32'hF800, 5'b00101);
      send(1'b0, ROL, 32'h8001, 32'h0001, 2'b00, 32'h0003, 5'b00001);
      send(1'b0, LSR, 32'h1234, 32'h0010, 2'b00, 32'h1234, 5'b00001);
      send(1'b0, PAS, 32'hF0F0, 32'hFF00, 2'b11, 32'hF0F0, 5'b00101);
      send(1'b0, NAN, 32'hF0F0, 32'hFF00, 2'b11, 32'h0FFF, 5'b00001);
      send(1'b0, NOR, 32'hF0F0, 32'hFF00, 2'b11, 32'h000F, 5'b00001);
      send(1'b0, XNR, 32'hF0F0, 32'hFF00, 2'b11, 32'hF00F, 5'b00101);
      send(1'b0, NOT, 32'hF0F0, 32'hFF00, 2'b11, 32'h0F0F, 5'b00001);
      send(1'b0, AND, 32'hF0F0, 32'hFF00, 2'b11, 32'hF000, 5'b00101);
      send(1'b0, ORR, 32'hF0F0, 32'hFF00, 2'b11, 32'hFFF0, 5'b00101);
      send(1'b0, XOR, 32'hF0F0, 32'hFF00, 2'b11, 32'h0FF0, 5'b00001);
      send(1'b0, XOR, 32'h5555, 32'h5555, 2'b10, 32'h0000, 5'b01001);
      send(1'b0, ROR, 32'h0001, 32'h0001, 2'b00, 32'h8000, 5'b00101);
      send(1'b0, LSL, 32'h0001, 32'h000F, 2'b00, 32'h8000, 5'b00101);
      send(1'b0, ASL, 32'hC003, 32'h0002, 2'b00, 32'h000C, 5'b00001);
      send(1'b0, LSR, 32'h8000, 32'h000F, 2'b00, 32'h0001, 5'b00001);
      // Signed overflow and explicit carry-in
      send(1'b0, ADD, 32'h7FFF, 32'h0001, 2'b00, 32'h8000, 5'b00110);
      send(1'b0, SUB, 32'h8000, 32'h0001, 2'b00, 32'h7FFF, 5'b00010);
      send(1'b0, ADD, 32'h0001, 32'h0001, 2'b10, 32'h0003, 5'b00000);
      send(1'b0, SUB, 32'h0005, 32'h0003, 2'b10, 32'h0001, 5'b00000);
      drain();

      // Backpressure: consumer stalls, four ADDs queued behind
      @(posedge clk); #1;
      or16 = 1'b0;
      fork
         begin
            send(1'b0, ADD, 32'h0001, 32'h0001, 2'b00, 32'h0002, 5'b00000);
            send(1'b0, ADD, 32'hFFFF, 32'h0002, 2'b00, 32'h0001, 5'b10001);
            send(1'b0, ADD, 32'h0005, 32'h0006, 2'b01, 32'h000C, 5'b00000);
            send(1'b0, ADD, 32'h8000, 32'h8000, 2'b00, 32'h0000, 5'b11011);
         end
         begin
            t = 0;
            while (!ov16 && t < 20) begin
               @(negedge clk);
               t++;
            end
            check("bp_out_valid", 64'(ov16), 64'd1);
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready", 64'(ir16), 64'd0);
               check("bp_hold_c", 64'({c16, co16, cf16}), 64'({16'h0002, 2'b00}));
            end
            @(posedge clk); #1;
            or16 = 1'b1;
         end
      join
      drain();
      check("bp_final_cf", 64'(cf16), 64'd1);

      // Reset with two ops in flight
      send(1'b0, ADD, 32'hFFFF, 32'h0001, 2'b00, 32'h0000, 5'b11001);
      send(1'b0, ADD, 32'h0001, 32'h0001, 2'b00, 32'h0002, 5'b00000);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_clear", 64'({ov16, cf16, c16}), 64'd0);
      q16.delete();
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, ADD, 32'h0003, 32'h0004, 2'b01, 32'h0007, 5'b00000);
      check("rst_lat_cycle1", 64'(ov16), 64'd0);
      @(posedge clk); #1;
      check("rst_lat_cycle2", 64'(ov16), 64'd1);
      drain();

      // 32-bit instance
      send(1'b1, ROR, 32'h0000_0001, 32'd31, 2'b00, 32'h0000_0002, 5'b00000);
      send(1'b1, ADD, 32'hFFFF_FFFF, 32'h1,  2'b00, 32'h0000_0000, 5'b11001);
      send(1'b1, ASR, 32'h8000_0000, 32'd31, 2'b00, 32'hFFFF_FFFF, 5'b00101);
      send(1'b1, ADD, 32'h0000_0000, 32'h0,  2'b01, 32'h0000_0001, 5'b00000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
